// File: rtl/regfile_dump_ctrl.sv
// Register-file dump sequencer: walks debug read port 0..NUM_REGS-1, streams bytes MSB first.
// Optional REGDUMP_CHECKSUM_EN appends an XOR checksum byte after the last register.
module regfile_dump_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              dbg_on,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LOAD, S_SEND, S_CSUM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LOAD, S_SEND, S_DONE} state_t;
`endif

  state_t              state, state_next;
  logic [ADDR_W-1:0]   index;
  logic [BCNT_W-1:0]   byte_cnt;
  logic [DATA_W-1:0]   shift;
  logic                handshake;
  logic                last_byte;
  logic                last_reg;

  assign handshake = tx_valid && tx_ready;
  assign last_byte = (byte_cnt == BCNT_W'(BYTES - 1));
  assign last_reg  = (index == ADDR_W'(NUM_REGS - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (start) state_next = S_ADDR;
      S_ADDR: state_next = S_LOAD;
      S_LOAD: state_next = S_SEND;
      S_SEND: begin
        if (handshake && last_byte) begin
          if (!last_reg)
            state_next = S_ADDR;
          else
`ifdef REGDUMP_CHECKSUM_EN
            state_next = S_CSUM;
`else
            state_next = S_DONE;
`endif
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      S_CSUM: if (handshake) state_next = S_DONE;
`endif
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Abort outranks any handshake landing on the same edge, including the final one.
    if (abort && state != S_IDLE) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index    <= '0;
      byte_cnt <= '0;
      shift    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) index <= '0;
          byte_cnt <= '0;
        end
        S_LOAD: begin
          shift    <= dbg_data;
          byte_cnt <= '0;
        end
        S_SEND: begin
          if (handshake) begin
            shift    <= shift << 8;
            byte_cnt <= byte_cnt + 1'b1;
            if (last_byte && !last_reg) index <= index + 1'b1;
          end
        end
        S_DONE: index <= '0;
        default: ;
      endcase
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (rst)                                csum <= 8'h00;
    else if (state == S_IDLE && start)      csum <= 8'h00;
    else if (state == S_SEND && handshake)  csum <= csum ^ tx_data;
  end
`endif

  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    dbg_on   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    unique case (state)
      S_ADDR, S_LOAD: dbg_on = 1'b1;
      S_SEND: begin
        dbg_on   = 1'b1;
        tx_valid = 1'b1;
        tx_data  = shift[DATA_W-1 -: 8];
      end
`ifdef REGDUMP_CHECKSUM_EN
      S_CSUM: begin
        dbg_on   = 1'b1;
        tx_valid = 1'b1;
        tx_data  = csum;
      end
`endif
      default: ;
    endcase
    dbg_addr = dbg_on ? index : '0;
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Testbench for regfile_dump_ctrl: cycle vector table plus full dumps checked against a byte-stream model.
module tb_regfile_dump_ctrl;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int BYTES    = DATA_W / 8;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int TOTAL    = NUM_REGS * BYTES + CS;
  localparam int MIN_DONE = NUM_REGS * (2 + BYTES) + CS;

  logic              clk = 1'b0;
  logic              rst, start, abort, tx_ready;
  logic              busy, done, dbg_on, tx_valid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data = '0;
  logic [7:0]        tx_data;

  regfile_dump_ctrl #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .dbg_on(dbg_on), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // Register file debug port model: read data refreshes on the falling edge.
  logic [DATA_W-1:0] rf [NUM_REGS];
  always @(negedge clk) if (dbg_on) dbg_data <= rf[dbg_addr];

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] got   [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic build_model();
    logic [7:0] x;
    exp_q.delete();
    for (int r = 0; r < NUM_REGS; r++)
      for (int b = 0; b < BYTES; b++)
        exp_q.push_back(rf[r][DATA_W-1-8*b -: 8]);
    x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
    if (CS == 1) exp_q.push_back(x);
  endtask

  task automatic compare_stream(input string name, input int n);
    int mism = 0;
    check({name, "_len"}, got.size(), n);
    for (int i = 0; i < got.size() && i < n; i++)
      if (got[i] !== exp_q[i]) mism++;
    check({name, "_bytes"}, mism, 0);
  endtask

  // Drives one dump from a start pulse; optional stall, repeated start, abort or reset injection.
  task automatic run_dump(input bit rand_ready, input int stall_at, input int restart_at,
                          input int abort_at, input int rst_reg,
                          output int done_cycle, output int n_done);
    int cyc, stall_cnt, low_cnt, late_done;
    bit restarted, seen_done;
    got.delete();
    done_cycle = -1; n_done = 0; stall_cnt = 0; low_cnt = 0;
    restarted = 0; seen_done = 0;
    start = 1'b1; abort = 1'b0; tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 3000) begin
      if (seen_done) begin
        check("done_single_then_idle", {done, busy, dbg_on, tx_valid}, 4'b0000);
        return;
      end
      if (done) begin
        n_done++;
        done_cycle = cyc;
        seen_done  = 1;
      end
      tx_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = 1'b0;
      abort = 1'b0;
      if (tx_valid && got.size() == stall_at && stall_cnt < 10) begin
        tx_ready = 1'b0;
        check("stall_hold", {tx_valid, tx_data}, {1'b1, exp_q[stall_at]});
        stall_cnt++;
      end
      if (tx_valid && got.size() == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
      if (tx_valid && got.size() == abort_at) begin
        abort = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_outputs", {busy, done, dbg_on, dbg_addr, tx_valid}, '0);
        late_done = 0;
        repeat (5) begin
          @(posedge clk); #1;
          if (done || busy) late_done++;
        end
        check("abort_no_done", late_done, 0);
        return;
      end
      if (rst_reg >= 0 && dbg_on && !tx_valid && dbg_addr == rst_reg) begin
        low_cnt++;
        if (low_cnt == 2) begin
          rst = 1'b1;
          @(posedge clk); #1;
          check("rst_mid_dump_outputs",
                {busy, done, dbg_on, dbg_addr, tx_valid, tx_data}, '0);
          rst = 1'b0;
          return;
        end
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      @(posedge clk); #1;
      cyc++;
    end
    check("dump_within_budget", 0, 1);
  endtask

  typedef struct {
    logic       start, abort, ready;
    logic       busy, done, on;
    logic [4:0] addr;
    logic       valid;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [17];
  int   dc, nd;
  logic [7:0] x;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = '0;
    for (int i = 1; i <= 16; i++) rf[i] = {8'(i), 8'hC3, 8'(i * 3), 8'h5A};
    rf[0]  = 32'h0000_0001;
    rf[1]  = 32'h0000_0011;
    rf[8]  = 32'h0000_0004;
    rf[31] = 32'd42;
    build_model();

    //           st ab rd | busy done on addr valid data
    vecs[0]  = '{1, 0, 1,  1, 0, 1, 5'd0, 0, 8'h00};
    vecs[1]  = '{0, 0, 1,  1, 0, 1, 5'd0, 0, 8'h00};
    vecs[2]  = '{0, 0, 0,  1, 0, 1, 5'd0, 1, 8'h00};
    vecs[3]  = '{0, 0, 0,  1, 0, 1, 5'd0, 1, 8'h00};
    vecs[4]  = '{0, 0, 1,  1, 0, 1, 5'd0, 1, 8'h00};
    vecs[5]  = '{0, 0, 1,  1, 0, 1, 5'd0, 1, 8'h00};
    vecs[6]  = '{0, 0, 1,  1, 0, 1, 5'd0, 1, 8'h01};
    vecs[7]  = '{0, 0, 1,  1, 0, 1, 5'd1, 0, 8'h00};
    vecs[8]  = '{0, 0, 1,  1, 0, 1, 5'd1, 0, 8'h00};
    vecs[9]  = '{0, 0, 1,  1, 0, 1, 5'd1, 1, 8'h00};
    vecs[10] = '{0, 0, 1,  1, 0, 1, 5'd1, 1, 8'h00};
    vecs[11] = '{0, 0, 1,  1, 0, 1, 5'd1, 1, 8'h00};
    vecs[12] = '{0, 0, 1,  1, 0, 1, 5'd1, 1, 8'h11};
    vecs[13] = '{0, 1, 0,  0, 0, 0, 5'd0, 0, 8'h00};
    vecs[14] = '{0, 0, 0,  0, 0, 0, 5'd0, 0, 8'h00};
    vecs[15] = '{1, 1, 0,  1, 0, 1, 5'd0, 0, 8'h00};
    vecs[16] = '{0, 1, 0,  0, 0, 0, 5'd0, 0, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, dbg_on, dbg_addr, tx_valid, tx_data}, '0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      start = vecs[i].start; abort = vecs[i].abort; tx_ready = vecs[i].ready;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), {busy, done, dbg_on, dbg_addr, tx_valid, tx_data},
            {vecs[i].busy, vecs[i].done, vecs[i].on, vecs[i].addr, vecs[i].valid, vecs[i].data});
    end
    start = 1'b0; abort = 1'b0;

    // Full dump at full rate: stream contents and done latency.
    run_dump(0, -1, -1, -1, -1, dc, nd);
    compare_stream("full", TOTAL);
    check("full_done_count", nd, 1);
    check("full_done_cycle", dc, MIN_DONE);
`ifdef REGDUMP_CHECKSUM_EN
    x = 8'h00;
    for (int i = 0; i < TOTAL - 1 && i < got.size(); i++) x ^= got[i];
    check("csum_byte", got[TOTAL-1], x);
`endif

    // Ten-cycle stall on the last byte of r8.
    run_dump(0, 8 * BYTES + 3, -1, -1, -1, dc, nd);
    compare_stream("stall", TOTAL);
    check("stall_done_cycle", dc, MIN_DONE + 10);

    // Second start while busy during r5 is ignored.
    run_dump(0, -1, 5 * BYTES + 1, -1, -1, dc, nd);
    compare_stream("restart", TOTAL);
    check("restart_done_count", nd, 1);
    check("restart_done_cycle", dc, MIN_DONE);

    // Abort during r12 drops the pending byte; the next dump starts from r0.
    run_dump(0, -1, -1, 12 * BYTES + 1, -1, dc, nd);
    compare_stream("abort_prefix", 12 * BYTES + 1);
    run_dump(0, -1, -1, -1, -1, dc, nd);
    compare_stream("after_abort", TOTAL);
    check("after_abort_first_word", {got[0], got[1], got[2], got[3]}, 32'h0000_0001);

    // Abort colliding with the final handshake suppresses done.
    run_dump(0, -1, -1, TOTAL - 1, -1, dc, nd);
    compare_stream("abort_last", TOTAL - 1);

    // Reset during LOAD of r20.
    run_dump(0, -1, -1, -1, 20, dc, nd);
    compare_stream("rst_prefix", 20 * BYTES);

    // Randomized back-pressure across several dumps.
    for (int k = 0; k < 3; k++) begin
      run_dump(1, -1, -1, -1, -1, dc, nd);
      compare_stream($sformatf("rand%0d", k), TOTAL);
      check($sformatf("rand%0d_done_count", k), nd, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
